// File: rtl/parallel_ctrl_pkg.sv
// Shared types and constants for the Parallel_module sequencer: state encoding,
// phase lengths and the fixed select codes used during load and park.
package parallel_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } state_t;

   localparam int LOAD_LEN  = 4;
   localparam int SCHED_LEN = 12;

   localparam logic [3:0] PARK_CODE = 4'd7;

   // Load phase: s1 walks 2,1,0,0 while we_1 covers L1..L2 and we_2 covers L3.
   function automatic logic [3:0] load_s1_code(input logic [1:0] idx);
      case (idx)
         2'd0:    load_s1_code = 4'd2;
         2'd1:    load_s1_code = 4'd1;
         default: load_s1_code = 4'd0;
      endcase
   endfunction

   function automatic logic load_we1(input logic [1:0] idx);
      load_we1 = (idx == 2'd1) || (idx == 2'd2);
   endfunction

   function automatic logic load_we2(input logic [1:0] idx);
      load_we2 = (idx == 2'd3);
   endfunction

endpackage

// File: rtl/parallel_sched_rom.sv
// Compute schedule for Parallel_module.s0: index 0..11 maps to the kernel
// select code; indices past the end map to the park code.
module parallel_sched_rom
   import parallel_ctrl_pkg::*;
(
   input  logic [3:0] index,
   output logic [3:0] code
);

   always_comb begin
      code = PARK_CODE;
      case (index)
         4'd0:    code = 4'd0;
         4'd1:    code = 4'd1;
         4'd2:    code = 4'd2;
         4'd3:    code = 4'd4;
         4'd4:    code = 4'd5;
         4'd5:    code = 4'd6;
         4'd6:    code = 4'd1;
         4'd7:    code = 4'd2;
         4'd8:    code = 4'd3;
         4'd9:    code = 4'd5;
         4'd10:   code = 4'd6;
         4'd11:   code = 4'd7;
         default: code = PARK_CODE;
      endcase
   end

endmodule

// File: rtl/parallel_ctrl.sv
// Sequencer driving Parallel_module: a 4-cycle load phase on s1/we_1/we_2,
// then the 12-entry s0 compute schedule, then s0 parked on the final code.
module parallel_ctrl
   import parallel_ctrl_pkg::*;
#(
   parameter int STEP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   output logic [3:0] s0,
   output logic [3:0] s1,
   output logic       we_1,
   output logic       we_2,
   output logic       busy,
   output logic       done,
   output logic [3:0] step
);

   localparam logic [1:0] LOAD_LAST  = 2'(LOAD_LEN - 1);
   localparam logic [3:0] SCHED_LAST = 4'(SCHED_LEN - 1);
   localparam logic [3:0] HOLD_LAST  = 4'(STEP_CYCLES - 1);

   state_t     state;
   logic [1:0] load_cnt;
   logic [3:0] hold_cnt;
   logic [3:0] rom_index;
   logic [3:0] rom_code;

   // The ROM always looks up the entry that will be shown after the next
   // boundary, so s0 can be registered together with the step change.
   assign rom_index = (state == ST_RUN) ? step + 4'd1 : 4'd0;

   parallel_sched_rom u_rom (
      .index (rom_index),
      .code  (rom_code)
   );

   always_ff @(posedge clk) begin
      if (!rst || abort) begin
         state    <= ST_IDLE;
         load_cnt <= 2'd0;
         hold_cnt <= 4'd0;
         step     <= 4'd0;
         s0       <= 4'd0;
         s1       <= 4'd0;
         we_1     <= 1'b0;
         we_2     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (start) begin
                  state    <= ST_LOAD;
                  load_cnt <= 2'd0;
                  s0       <= 4'd0;
                  s1       <= load_s1_code(2'd0);
                  we_1     <= load_we1(2'd0);
                  we_2     <= load_we2(2'd0);
                  busy     <= 1'b1;
               end
            end

            ST_LOAD: begin
               if (load_cnt == LOAD_LAST) begin
                  state    <= ST_RUN;
                  step     <= 4'd0;
                  hold_cnt <= 4'd0;
                  s0       <= rom_code;
                  s1       <= 4'd0;
                  we_1     <= 1'b0;
                  we_2     <= 1'b0;
               end else begin
                  load_cnt <= load_cnt + 2'd1;
                  s1       <= load_s1_code(load_cnt + 2'd1);
                  we_1     <= load_we1(load_cnt + 2'd1);
                  we_2     <= load_we2(load_cnt + 2'd1);
               end
            end

            // The hold counter only advances within an entry and reloads on every boundary.
            ST_RUN: begin
               if (hold_cnt == HOLD_LAST) begin
                  hold_cnt <= 4'd0;
                  if (step == SCHED_LAST) begin
                     state <= ST_DONE;
                     step  <= 4'd0;
                     s0    <= PARK_CODE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     step <= step + 4'd1;
                     s0   <= rom_code;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 4'd1;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_parallel_ctrl.sv
// Directed bench for parallel_ctrl: one instance with single-cycle steps and one
// holding each schedule entry for three cycles, checked through per-DUT scoreboards.
module tb_parallel_ctrl;

   typedef struct packed {
      logic [3:0] s0;
      logic [3:0] s1;
      logic       we_1;
      logic       we_2;
      logic       busy;
      logic       done;
      logic [3:0] step;
   } exp_t;

   logic clk;
   logic rst;
   logic start_a, abort_a, start_b, abort_b;

   logic [3:0] s0_a, s1_a, step_a, s0_b, s1_b, step_b;
   logic       we_1_a, we_2_a, busy_a, done_a;
   logic       we_1_b, we_2_b, busy_b, done_b;

   exp_t q_a[$];
   exp_t q_b[$];
   int   checks = 0;
   int   errors = 0;

   logic [3:0] sched_tbl   [12] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6,
                                    4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7};
   logic [3:0] load_s1_tbl [4]  = '{4'd2, 4'd1, 4'd0, 4'd0};

   parallel_ctrl #(.STEP_CYCLES(1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
      .s0(s0_a), .s1(s1_a), .we_1(we_1_a), .we_2(we_2_a),
      .busy(busy_a), .done(done_a), .step(step_a)
   );

   parallel_ctrl #(.STEP_CYCLES(3)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
      .s0(s0_b), .s1(s1_b), .we_1(we_1_b), .we_2(we_2_b),
      .busy(busy_b), .done(done_b), .step(step_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t idle_exp();
      return '0;
   endfunction

   function automatic exp_t load_exp(input int i);
      exp_t e = '0;
      e.s1   = load_s1_tbl[i];
      e.we_1 = (i == 1) || (i == 2);
      e.we_2 = (i == 3);
      e.busy = 1'b1;
      return e;
   endfunction

   function automatic exp_t run_exp(input int i);
      exp_t e = '0;
      e.s0   = sched_tbl[i];
      e.busy = 1'b1;
      e.step = 4'(i);
      return e;
   endfunction

   function automatic exp_t done_exp(input logic first);
      exp_t e = '0;
      e.s0   = 4'd7;
      e.done = first;
      return e;
   endfunction

   task automatic applyStimulus(input logic sa, input logic aa, input logic sb,
                                input logic ab, input logic r);
      start_a = sa;
      abort_a = aa;
      start_b = sb;
      abort_b = ab;
      rst     = r;
   endtask

   task automatic expectOut(input bit to_b, input exp_t e);
      if (to_b) q_b.push_back(e);
      else      q_a.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      exp_t obs;
      if (q_a.size() > 0) begin
         e   = q_a.pop_front();
         obs = {s0_a, s1_a, we_1_a, we_2_a, busy_a, done_a, step_a};
         checks++;
         assert (obs === e) else begin
            errors++;
            $error("[TB] FAIL dut_a t=%0t observed s0=%h s1=%h we=%b%b busy=%b done=%b step=%h expected s0=%h s1=%h we=%b%b busy=%b done=%b step=%h",
                   $time, obs.s0, obs.s1, obs.we_1, obs.we_2, obs.busy, obs.done, obs.step,
                   e.s0, e.s1, e.we_1, e.we_2, e.busy, e.done, e.step);
         end
      end
      if (q_b.size() > 0) begin
         e   = q_b.pop_front();
         obs = {s0_b, s1_b, we_1_b, we_2_b, busy_b, done_b, step_b};
         checks++;
         assert (obs === e) else begin
            errors++;
            $error("[TB] FAIL dut_b t=%0t observed s0=%h s1=%h we=%b%b busy=%b done=%b step=%h expected s0=%h s1=%h we=%b%b busy=%b done=%b step=%h",
                   $time, obs.s0, obs.s1, obs.we_1, obs.we_2, obs.busy, obs.done, obs.step,
                   e.s0, e.s1, e.we_1, e.we_2, e.busy, e.done, e.step);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic setStart(input bit to_b, input logic v);
      if (to_b) applyStimulus(1'b0, 1'b0, v, 1'b0, 1'b1);
      else      applyStimulus(v, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // Full load/run/done sequence; restart_cycle is the cycle (relative to k)
   // during which a stray start is held high, or -1 for none.
   task automatic runSequence(input bit to_b, input int hold, input int restart_cycle);
      int cyc;
      setStart(to_b, 1'b1);
      expectOut(to_b, load_exp(0));
      tick();
      setStart(to_b, 1'b0);
      for (int i = 1; i < 4; i++) begin
         expectOut(to_b, load_exp(i));
         tick();
      end
      cyc = 5;
      for (int i = 0; i < 12; i++) begin
         for (int h = 0; h < hold; h++) begin
            setStart(to_b, (cyc - 1) == restart_cycle);
            expectOut(to_b, run_exp(i));
            tick();
            cyc++;
         end
      end
      setStart(to_b, 1'b0);
      expectOut(to_b, done_exp(1'b1));
      tick();
      expectOut(to_b, done_exp(1'b0));
      tick();
      expectOut(to_b, done_exp(1'b0));
      tick();
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expectOut(1'b0, idle_exp());
      expectOut(1'b1, idle_exp());
      tick();
      expectOut(1'b0, idle_exp());
      expectOut(1'b1, idle_exp());
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expectOut(1'b0, idle_exp());
      tick();

      $display("[TB] basic run with a stray start at k+8");
      runSequence(1'b0, 1, 8);

      $display("[TB] restart from DONE");
      runSequence(1'b0, 1, -1);

      $display("[TB] abort during L2");
      setStart(1'b0, 1'b1);
      expectOut(1'b0, load_exp(0));
      tick();
      setStart(1'b0, 1'b0);
      expectOut(1'b0, load_exp(1));
      tick();
      expectOut(1'b0, load_exp(2));
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      expectOut(1'b0, idle_exp());
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expectOut(1'b0, idle_exp());
      tick();

      $display("[TB] start and abort together in IDLE");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      expectOut(1'b0, idle_exp());
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expectOut(1'b0, idle_exp());
      tick();

      $display("[TB] reset mid-RUN at step 6");
      setStart(1'b0, 1'b1);
      expectOut(1'b0, load_exp(0));
      tick();
      setStart(1'b0, 1'b0);
      for (int i = 1; i < 4; i++) begin
         expectOut(1'b0, load_exp(i));
         tick();
      end
      for (int i = 0; i < 7; i++) begin
         expectOut(1'b0, run_exp(i));
         tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expectOut(1'b0, idle_exp());
      expectOut(1'b1, idle_exp());
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      expectOut(1'b0, idle_exp());
      tick();
      runSequence(1'b0, 1, -1);

      $display("[TB] three-cycle hold per schedule entry");
      runSequence(1'b1, 3, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/parallel_ctrl.md
# parallel_ctrl

Sequencer for `Parallel_module`, the 4x4-input / 3x3-kernel parallel datapath. After a single-cycle `start`, it replaces hand-driven stimulus. It first runs the fixed 4-cycle load phase on `s1`/`we_1`/`we_2`, then steps `s0` through the 12-entry compute schedule, then parks `s0` on the final code. It sits between the top-level control and `Parallel_module`, and drives that module's select and write-enable inputs directly.

## Interface
Parameters:
- `STEP_CYCLES`, default 1: cycles each compute-schedule entry is held on `s0`. Legal range 1..15.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle request to run load plus compute; sampled only in IDLE and DONE.
- `abort`  in  1  return to IDLE on the next edge from any state.
- `s0`  out  4  compute-select to `Parallel_module.s0`.
- `s1`  out  4  load-select to `Parallel_module.s1`.
- `we_1`  out  1  write enable 1 to the datapath.
- `we_2`  out  1  write enable 2 to the datapath.
- `busy`  out  1  high while in LOAD or RUN.
- `done`  out  1  one-cycle pulse on entry to DONE.
- `step`  out  4  current compute-schedule index 0..11 in RUN; 0 otherwise.

## Operation
- All outputs are registered. Reset (`rst`=0 at an edge) gives: state IDLE, `s0`=0, `s1`=0, `we_1`=0, `we_2`=0, `busy`=0, `done`=0, `step`=0, all counters 0.
- States: IDLE, LOAD, RUN, DONE.
- **IDLE**: outputs at their reset values. `start`=1 moves to LOAD, load index 0.
- **LOAD**: exactly 4 cycles, each given as (`s1`, `we_1`, `we_2`):
  - L0: (2, 0, 0)
  - L1: (1, 1, 0)
  - L2: (0, 1, 0)
  - L3: (0, 0, 1)
  - `s0`=0 throughout LOAD. After L3, go to RUN at index 0.
- **RUN**: `s0` = SCHED[`step`], with `s1`=0 and both write enables 0.
  - SCHED = 0,1,2,4,5,6,1,2,3,5,6,7.
  - Each entry is held STEP_CYCLES cycles by a hold counter, then `step` increments.
  - When index 11 completes its hold, go to DONE.
- **DONE**: `s0` held at 7, `busy`=0, `step`=0, `done`=1 only in the first DONE cycle.
  - `start`=1 moves to LOAD L0 (a restart, with no pass through IDLE).
  - Otherwise DONE persists.
- **`abort`**: highest priority after `rst`. From any state it moves to IDLE with reset output values on the next edge, and `done` is not pulsed.
  - `start` and `abort` in the same cycle: `abort` wins.
- `start` during LOAD or RUN is ignored. No queuing.
- `s0`/`s1` codes outside the listed values are never driven.

## Timing
- `start` sampled at edge k (state IDLE or DONE):
  - L0 outputs valid and `busy`=1 in cycle k+1.
  - L3 is in cycle k+4.
  - SCHED[0] is in cycle k+5.
- RUN occupies 12×STEP_CYCLES cycles. DONE is entered, with the `done` pulse and `busy` low, in cycle k+5+12×STEP_CYCLES.
  - With STEP_CYCLES=1: `busy` lasts 16 cycles and `done` is in cycle k+17.
- `s0` changes only at entry boundaries, and never glitches between two entries within a hold.
- `rst` or `abort` asserted mid-LOAD, with `we_1` or `we_2` high, drops those enables in the very next cycle.
- The hold counter reloads on every entry change, and wraps only by reload, never free-running.

## Structure
- Package `parallel_ctrl_pkg` holds:
  - state enum (IDLE, LOAD, RUN, DONE);
  - `LOAD_LEN`=4 and `SCHED_LEN`=12;
  - the load-phase `s1` codes (2, 1, 0, 0) and the final park code 7.
- Sub-module `parallel_sched_rom`: combinational 4-bit index to 4-bit `s0` code holding SCHED. It is shared with the verification model.
- The top holds the state register, the 2-bit load counter, the 4-bit schedule index and the 4-bit hold counter.

## Test plan
- Reset then `start`, STEP_CYCLES=1:
  - (`s1`, `we_1`, `we_2`) over cycles k+1..k+4 = (2,0,0), (1,1,0), (0,1,0), (0,0,1);
  - `s0` over k+5..k+16 = 0,1,2,4,5,6,1,2,3,5,6,7;
  - `done` only in cycle k+17; `s0` stays 7 afterwards.
- STEP_CYCLES=3: each SCHED entry is held exactly 3 cycles, `step` goes 0..11, and `done` falls in cycle k+41.
- `abort` in cycle k+3 (during L2, `we_1`=1): in k+4 all outputs are 0, state IDLE, no `done` pulse.
- `start` pulsed again at cycle k+8 (in RUN): ignored; schedule and `done` timing are identical to the first scenario.
- From DONE, `start`: L0 appears on the next cycle and the full sequence repeats. `start`+`abort` together in IDLE: stays IDLE, `busy`=0.
- `rst`=0 mid-RUN (`step`=6): all outputs at reset values on the next cycle; a subsequent `start` runs a clean full sequence.
